// File: rtl/pconv_cn_pkg.sv
// Shared definitions for the pointwise convolution block: FSM state
// encodings and the widths used by the round/shift/saturate stage.
package pconv_cn_pkg;

  // Frame-level control states; busy is high in RUN and DRAIN.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Width of each per-channel right-shift field.
  localparam int SHIFT_W = 5;

  // Extra headroom bit so adding the rounding constant can never wrap.
  localparam int ROUND_GUARD = 1;

  // Counter width that stays legal when the count is 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pconv_cn_if.sv
// Beat input / result output bundle for pconv_cn.
// The master side drives activations, weights, bias, shift and result ready;
// the slave side (the convolution engine) returns results and status.
interface pconv_cn_if #(
  parameter int N              = 16,
  parameter int OUTPUT_CHANNEL = 32,
  parameter int ACC_W          = 32
) ();
  import pconv_cn_pkg::*;

  logic                             input_vld;
  logic                             input_rdy;
  logic [N-1:0]                     input_din;
  logic [OUTPUT_CHANNEL*N-1:0]      weight_din;
  logic [OUTPUT_CHANNEL*ACC_W-1:0]  bias_din;
  logic [OUTPUT_CHANNEL*SHIFT_W-1:0] shift_din;
  logic [OUTPUT_CHANNEL*N-1:0]      conv_dout;
  logic                             conv_dout_vld;
  logic                             conv_dout_rdy;
  logic                             conv_dout_last;
  logic                             busy;

  modport master (
    output input_vld, input_din, weight_din, bias_din, shift_din, conv_dout_rdy,
    input  input_rdy, conv_dout, conv_dout_vld, conv_dout_last, busy
  );

  modport slave (
    input  input_vld, input_din, weight_din, bias_din, shift_din, conv_dout_rdy,
    output input_rdy, conv_dout, conv_dout_vld, conv_dout_last, busy
  );

endinterface

// File: rtl/pconv_mac_cn.sv
// One output channel: signed multiply-accumulate over the input channels of a
// pixel, then round-half-up, arithmetic right shift, saturation and optional
// ReLU into the held result register.
module pconv_mac_cn
  import pconv_cn_pkg::*;
#(
  parameter int N     = 16,
  parameter int ACC_W = 32,
  parameter int RELU  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     beat_en,   // beat accepted this cycle
  input  logic                     first_ch,  // beat is channel 0 of a pixel
  input  logic                     load_out,  // beat is the last channel
  input  logic signed [N-1:0]      x,
  input  logic signed [N-1:0]      w,
  input  logic signed [ACC_W-1:0]  bias,
  input  logic [SHIFT_W-1:0]       shift,
  output logic [N-1:0]             q
);

  localparam int RW = ACC_W + ROUND_GUARD;
  localparam logic signed [RW-1:0] MAX_V = {{(RW-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [RW-1:0] MIN_V = {{(RW-N+1){1'b1}}, {(N-1){1'b0}}};

  logic signed [ACC_W-1:0] acc_reg;
  logic signed [ACC_W-1:0] prod;
  logic signed [ACC_W-1:0] sum_next;
  logic signed [RW-1:0]    round_inc;
  logic signed [RW-1:0]    rounded;
  logic signed [RW-1:0]    shifted;
  logic signed [N-1:0]     sat_val;
  logic signed [N-1:0]     q_next;
  logic [N-1:0]            q_reg;

  // Product is taken modulo 2^ACC_W, matching the wrapping accumulator.
  assign prod = ACC_W'(x * w);

  // Accumulate, then round/shift/saturate/ReLU the running sum.
  always_comb begin
    sum_next  = (first_ch ? bias : acc_reg) + prod;
    round_inc = (shift == '0) ? '0 : (RW'(1) <<< (shift - 1'b1));
    rounded   = RW'(sum_next) + round_inc;
    shifted   = rounded >>> shift;
    if (shifted > MAX_V) begin
      sat_val = {1'b0, {(N-1){1'b1}}};
    end else if (shifted < MIN_V) begin
      sat_val = {1'b1, {(N-1){1'b0}}};
    end else begin
      sat_val = shifted[N-1:0];
    end
    q_next = ((RELU != 0) && sat_val[N-1]) ? '0 : sat_val;
  end

  // Accumulator advances on every accepted beat; result loads on the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg <= '0;
      q_reg   <= '0;
    end else begin
      if (beat_en) begin
        acc_reg <= sum_next;
      end
      if (load_out) begin
        q_reg <= q_next;
      end
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/pconv_cn.sv
// Pointwise (1x1) convolution engine. Activations arrive one input channel
// per beat; after INPUT_CHANNEL beats every output channel emits a result.
// A single held output register backpressures the input while occupied.
module pconv_cn
  import pconv_cn_pkg::*;
#(
  parameter int N              = 16,
  parameter int INPUT_CHANNEL  = 4,
  parameter int OUTPUT_CHANNEL = 32,
  parameter int INPUT_SIZE     = 6,
  parameter int ACC_W          = 32,
  parameter int RELU           = 1
) (
  input  logic       clk,
  input  logic       rst,
  pconv_cn_if.slave  bus
);

  localparam int PIX   = INPUT_SIZE * INPUT_SIZE;
  localparam int CI_W  = cnt_w(INPUT_CHANNEL);
  localparam int PIX_W = cnt_w(PIX);

  logic [CI_W-1:0]             ci_reg, ci_next;
  logic [PIX_W-1:0]            pix_reg, pix_next;
  logic                        vld_reg, vld_next;
  logic                        last_reg, last_next;
  state_t                      state_reg, state_next;
  logic                        accept, first_ch, last_ch, last_pix;
  logic                        load_out, frame_end, out_take;
  logic [OUTPUT_CHANNEL*N-1:0] dout_w;

  // Input is only blocked while a result is held and not being taken.
  assign bus.input_rdy = !vld_reg || bus.conv_dout_rdy;
  assign accept        = bus.input_vld && bus.input_rdy;
  assign first_ch      = (ci_reg == '0);
  assign last_ch       = (ci_reg == CI_W'(INPUT_CHANNEL - 1));
  assign last_pix      = (pix_reg == PIX_W'(PIX - 1));
  assign load_out      = accept && last_ch;
  assign frame_end     = load_out && last_pix;
  assign out_take      = vld_reg && bus.conv_dout_rdy;

  // Channel/pixel counters and output valid/last bookkeeping.
  always_comb begin
    ci_next   = ci_reg;
    pix_next  = pix_reg;
    vld_next  = vld_reg;
    last_next = last_reg;
    if (accept) begin
      if (last_ch) begin
        ci_next  = '0;
        pix_next = last_pix ? '0 : pix_reg + 1'b1;
      end else begin
        ci_next = ci_reg + 1'b1;
      end
    end
    if (load_out) begin
      vld_next  = 1'b1;
      last_next = last_pix;
    end else if (out_take) begin
      vld_next  = 1'b0;
      last_next = 1'b0;
    end
  end

  // Frame FSM: DRAIN waits for the final result to be taken.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = frame_end ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (frame_end) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_take && last_reg) begin
          if (accept) begin
            state_next = frame_end ? ST_DRAIN : ST_RUN;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      ci_reg    <= '0;
      pix_reg   <= '0;
      vld_reg   <= 1'b0;
      last_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      ci_reg    <= ci_next;
      pix_reg   <= pix_next;
      vld_reg   <= vld_next;
      last_reg  <= last_next;
    end
  end

  generate
    for (genvar gi = 0; gi < OUTPUT_CHANNEL; gi++) begin : g_mac
      pconv_mac_cn #(
        .N     (N),
        .ACC_W (ACC_W),
        .RELU  (RELU)
      ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .beat_en  (accept),
        .first_ch (first_ch),
        .load_out (load_out),
        .x        (bus.input_din),
        .w        (bus.weight_din[gi*N +: N]),
        .bias     (bus.bias_din[gi*ACC_W +: ACC_W]),
        .shift    (bus.shift_din[gi*SHIFT_W +: SHIFT_W]),
        .q        (dout_w[gi*N +: N])
      );
    end
  endgenerate

  assign bus.conv_dout      = dout_w;
  assign bus.conv_dout_vld  = vld_reg;
  assign bus.conv_dout_last = last_reg;
  assign bus.busy           = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_pconv_cn.sv
// Bench for pconv_cn: table of single-channel vectors on two IC=1 instances
// (ReLU on/off), hand sequences for latency and reset, and scoreboarded
// 6x6 frames with backpressure on a 4-input-channel instance.
module tb_pconv_cn;
  import pconv_cn_pkg::*;

  localparam int N = 16, IC = 4, OC = 2, SZ = 6, AW = 32, NPIX = SZ * SZ;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pconv_cn_if #(.N(N), .OUTPUT_CHANNEL(OC), .ACC_W(AW)) m ();
  pconv_cn_if #(.N(N), .OUTPUT_CHANNEL(OC), .ACC_W(AW)) a ();
  pconv_cn_if #(.N(N), .OUTPUT_CHANNEL(OC), .ACC_W(AW)) b ();

  pconv_cn #(.N(N), .INPUT_CHANNEL(IC), .OUTPUT_CHANNEL(OC), .INPUT_SIZE(SZ),
             .ACC_W(AW), .RELU(1)) u_main (.clk(clk), .rst(rst), .bus(m));
  pconv_cn #(.N(N), .INPUT_CHANNEL(1), .OUTPUT_CHANNEL(OC), .INPUT_SIZE(2),
             .ACC_W(AW), .RELU(1)) u_relu (.clk(clk), .rst(rst), .bus(a));
  pconv_cn #(.N(N), .INPUT_CHANNEL(1), .OUTPUT_CHANNEL(OC), .INPUT_SIZE(2),
             .ACC_W(AW), .RELU(0)) u_lin  (.clk(clk), .rst(rst), .bus(b));

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int chv(input logic [OC*N-1:0] v, input int o);
    logic signed [N-1:0] t;
    t = v[o*N +: N];
    return int'(t);
  endfunction

  // Reference: round half up, arithmetic shift, clamp to N bits, optional ReLU.
  function automatic int model_q(input int sum, input int s, input bit relu);
    longint r;
    r = longint'(sum);
    if (s > 0) r = r + (longint'(1) << (s - 1));
    r = r >>> s;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    if (relu && r < 0) r = 0;
    return int'(r);
  endfunction

  // Frame stimulus generators; pixel 0 is the x=1..4, w=1, bias=10 case.
  function automatic int gx(input int p, input int c);  return (c + 1) + p * 113 - (p % 4) * 400; endfunction
  function automatic int gw0(input int p, input int c); return (p == 0) ? 1 : (c * 700 - 900 + p * 7); endfunction
  function automatic int gw1(input int p, input int c); return (p == 0) ? 2 : (300 - c * 250 + p); endfunction
  function automatic int gb0(input int p); return (p == 0) ? 10 : (p * 1000 - 17000); endfunction
  function automatic int gb1(input int p); return (p == 0) ? -5 : (5000 - p * 333); endfunction
  function automatic int gs0(input int p); return (p == 0) ? 0 : (p % 6); endfunction
  function automatic int gs1(input int p); return (p == 0) ? 1 : ((p * 3) % 9); endfunction

  typedef struct {
    int x; int w0; int w1; int b0; int b1; int s0; int s1;
    int e0r; int e1r; int e0l; int e1l;
  } vec_t;
  vec_t tbl[8];

  typedef struct { int q0; int q1; bit last; } res_t;
  res_t exp_q[$];

  // Monitor state
  bit   mon_en = 0;
  int   stall_at = -1;
  int   stall_cnt = 0;
  int   stall_cycles = 0;
  int   n_res = 0;
  bit   busy_watch = 0;
  bit   busy_drop = 0;
  int   first0 = 0, first1 = 0;
  bit   held_valid = 0;
  logic [OC*N-1:0] held_dout;
  logic held_last;

  // Result sink for the main instance: drives ready, checks hold/stall/order.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      if (stall_at >= 0 && n_res >= stall_at && m.conv_dout_vld) begin
        stall_cnt = 5;
        stall_at  = -1;
      end
      m.conv_dout_rdy = (stall_cnt == 0);
      if (stall_cnt > 0) stall_cnt--;
      #4;
      if (busy_watch && !m.busy) busy_drop = 1;
      if (m.conv_dout_vld) begin
        if (held_valid) begin
          check("hold_dout", m.conv_dout, held_dout);
          check("hold_last", m.conv_dout_last, held_last);
        end
        if (!m.conv_dout_rdy) begin
          stall_cycles++;
          check("stall_input_rdy", m.input_rdy, 0);
          held_valid = 1;
          held_dout  = m.conv_dout;
          held_last  = m.conv_dout_last;
        end else begin
          res_t r;
          held_valid = 0;
          if (exp_q.size() == 0) begin
            check("unexpected_result_queue", exp_q.size(), 1);
          end else begin
            r = exp_q.pop_front();
            $display("result %0d: ch0=%0d ch1=%0d last=%0b", n_res,
                     chv(m.conv_dout, 0), chv(m.conv_dout, 1), m.conv_dout_last);
            check("frame_ch0", chv(m.conv_dout, 0), r.q0);
            check("frame_ch1", chv(m.conv_dout, 1), r.q1);
            check("frame_last", m.conv_dout_last, r.last);
            if (n_res == 0) begin
              first0 = chv(m.conv_dout, 0);
              first1 = chv(m.conv_dout, 1);
            end
          end
          n_res++;
        end
      end else begin
        held_valid = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one beat on the main instance and hold it until accepted.
  task automatic drive_beat(input int x, input int w0, input int w1, input int b0,
                            input int b1, input int s0, input int s1);
    int k;
    bit r;
    @(negedge clk);
    m.input_vld  = 1'b1;
    m.input_din  = N'(x);
    m.weight_din = {N'(w1), N'(w0)};
    m.bias_din   = {AW'(b1), AW'(b0)};
    m.shift_din  = {5'(s1), 5'(s0)};
    k = 0;
    forever begin
      #4;
      r = m.input_rdy;
      @(posedge clk);
      if (r) break;
      k++;
      if (k > 500) begin
        checks++;
        fails++;
        $display("FAIL beat_accept_timeout: input_rdy stayed 0, required 1");
        break;
      end
      @(negedge clk);
    end
  endtask

  // Send nbeats channel beats of pixel p; queue the expected result if complete.
  task automatic send_pixel(input int p, input int nbeats);
    int acc0, acc1, x, w0, w1;
    res_t r;
    acc0 = 0;
    acc1 = 0;
    for (int c = 0; c < nbeats; c++) begin
      x  = gx(p, c);
      w0 = gw0(p, c);
      w1 = gw1(p, c);
      drive_beat(x, w0, w1,
                 (c == 0) ? gb0(p) : 32'h1234_5678,
                 (c == 0) ? gb1(p) : -99999,
                 (c == IC - 1) ? gs0(p) : 31,
                 (c == IC - 1) ? gs1(p) : 31);
      if (c == 0) begin
        acc0 = gb0(p) + x * w0;
        acc1 = gb1(p) + x * w1;
      end else begin
        acc0 = acc0 + x * w0;
        acc1 = acc1 + x * w1;
      end
    end
    if (nbeats == IC) begin
      r.q0   = model_q(acc0, gs0(p), 1'b1);
      r.q1   = model_q(acc1, gs1(p), 1'b1);
      r.last = (p == NPIX - 1);
      exp_q.push_back(r);
    end
  endtask

  task automatic idle_input();
    @(negedge clk);
    m.input_vld = 1'b0;
  endtask

  task automatic wait_res(input int target, input string name);
    int k;
    k = 0;
    while (n_res < target && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check(name, n_res, target);
  endtask

  task automatic set_bus1(input vec_t v, input bit vld);
    a.input_vld  = vld;              b.input_vld  = vld;
    a.input_din  = N'(v.x);          b.input_din  = N'(v.x);
    a.weight_din = {N'(v.w1), N'(v.w0)};
    b.weight_din = {N'(v.w1), N'(v.w0)};
    a.bias_din   = {AW'(v.b1), AW'(v.b0)};
    b.bias_din   = {AW'(v.b1), AW'(v.b0)};
    a.shift_din  = {5'(v.s1), 5'(v.s0)};
    b.shift_din  = {5'(v.s1), 5'(v.s0)};
  endtask

  initial begin
    //           x      w0     w1      b0          b1   s0  s1  e0r    e1r  e0l     e1l
    tbl[0] = '{100,   400,   -400,   0,          0,   0,  0,  32767, 0,   32767,  -32768};
    tbl[1] = '{7,     1,     -1,     0,          0,   2,  2,  2,     0,   2,      -2};
    tbl[2] = '{1,     5,     5,      10,         -20, 0,  1,  15,    0,   15,     -7};
    tbl[3] = '{-3,    4,     -4,     0,          0,   0,  0,  0,     12,  -12,    12};
    tbl[4] = '{2,     3,     0,      5,          32,  3,  5,  1,     1,   1,      1};
    tbl[5] = '{32767, 32767, -32768, 0,          0,   15, 0,  32766, 0,   32766,  -32768};
    tbl[6] = '{1,     1,     0,      2147483647, -1,  0,  0,  0,     0,   -32768, -1};
    tbl[7] = '{-1,    1,     1,      0,          3,   1,  2,  0,     1,   0,      1};

    m.input_vld = 0; m.input_din = '0; m.weight_din = '0; m.bias_din = '0;
    m.shift_din = '0; m.conv_dout_rdy = 1'b1;
    set_bus1(tbl[0], 1'b0);
    a.conv_dout_rdy = 1'b1;
    b.conv_dout_rdy = 1'b1;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", m.conv_dout, 0);
    check("rst_vld", m.conv_dout_vld, 0);
    check("rst_last", m.conv_dout_last, 0);
    check("rst_busy", m.busy, 0);
    check("rst_input_rdy", m.input_rdy, 1);
    check("rst_ic1_dout", a.conv_dout, 0);
    @(negedge clk);
    rst = 1'b0;

    // Table vectors on the single-input-channel instances
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_bus1(tbl[i], 1'b1);
      @(posedge clk);
      #1;
      $display("vec %0d: relu=(%0d,%0d) lin=(%0d,%0d)", i, chv(a.conv_dout, 0),
               chv(a.conv_dout, 1), chv(b.conv_dout, 0), chv(b.conv_dout, 1));
      check("ic1_vld", a.conv_dout_vld & b.conv_dout_vld, 1);
      check("ic1_relu_ch0", chv(a.conv_dout, 0), tbl[i].e0r);
      check("ic1_relu_ch1", chv(a.conv_dout, 1), tbl[i].e1r);
      check("ic1_lin_ch0", chv(b.conv_dout, 0), tbl[i].e0l);
      check("ic1_lin_ch1", chv(b.conv_dout, 1), tbl[i].e1l);
      check("ic1_last", a.conv_dout_last, (i % 4) == 3);
    end
    @(negedge clk);
    set_bus1(tbl[0], 1'b0);
    @(posedge clk);
    #1;
    check("ic1_vld_clear", a.conv_dout_vld, 0);

    // Latency on a 4-channel pixel: x=1..4, w0=1, bias0=10 -> 20; ch1 -> 8
    for (int c = 0; c < IC; c++) begin
      drive_beat(c + 1, 1, 2, (c == 0) ? 10 : 777, (c == 0) ? -5 : 555,
                 (c == IC - 1) ? 0 : 7, (c == IC - 1) ? 1 : 7);
      #1;
      if (c < IC - 1) begin
        check("lat_early_vld", m.conv_dout_vld, 0);
      end else begin
        $display("pixel0: ch0=%0d ch1=%0d", chv(m.conv_dout, 0), chv(m.conv_dout, 1));
        check("lat_vld", m.conv_dout_vld, 1);
        check("lat_ch0", chv(m.conv_dout, 0), 20);
        check("lat_ch1", chv(m.conv_dout, 1), 8);
        check("lat_last", m.conv_dout_last, 0);
      end
    end
    idle_input();
    @(posedge clk);
    #1;
    check("lat_vld_clear", m.conv_dout_vld, 0);
    check("lat_busy_mid", m.busy, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Frame A with a 5-cycle output stall after result 10
    held_valid = 0;
    n_res = 0;
    stall_cycles = 0;
    stall_at = 10;
    mon_en = 1;
    for (int p = 0; p < NPIX; p++) send_pixel(p, IC);
    idle_input();
    wait_res(NPIX, "frameA_count");
    @(posedge clk);
    #1;
    check("frameA_busy_fall", m.busy, 0);
    check("frameA_queue_empty", exp_q.size(), 0);
    check("frameA_stall_cycles", stall_cycles, 5);

    // Frames B and C back to back: busy must never drop
    n_res = 0;
    busy_drop = 0;
    send_pixel(0, IC);
    busy_watch = 1;
    for (int p = 1; p < NPIX; p++) send_pixel(p, IC);
    for (int p = 0; p < NPIX; p++) send_pixel(p, IC);
    idle_input();
    wait_res(2 * NPIX, "b2b_count");
    busy_watch = 0;
    check("b2b_busy_hold", busy_drop, 0);
    @(posedge clk);
    #1;
    check("b2b_busy_fall", m.busy, 0);

    // Reset after two beats of pixel 5
    mon_en = 0;
    m.conv_dout_rdy = 1'b1;
    for (int p = 0; p < 5; p++) send_pixel(p, IC);
    send_pixel(5, 2);
    idle_input();
    exp_q.delete();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_dout", m.conv_dout, 0);
    check("midrst_vld", m.conv_dout_vld, 0);
    check("midrst_last", m.conv_dout_last, 0);
    check("midrst_busy", m.busy, 0);
    check("midrst_input_rdy", m.input_rdy, 1);
    @(negedge clk);
    rst = 1'b0;

    // Fresh frame after reset
    held_valid = 0;
    n_res = 0;
    mon_en = 1;
    for (int p = 0; p < NPIX; p++) send_pixel(p, IC);
    idle_input();
    wait_res(NPIX, "fresh_count");
    check("fresh_first_ch0", first0, 20);
    check("fresh_first_ch1", first1, 8);
    mon_en = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/pconv_cn.md
PCONV_CN -- requirements
Module: pconv_cn

Interface
REQ-001 SHALL have parameter N, default 16, meaning signed data/weight bit width.
REQ-002 SHALL have parameter INPUT_CHANNEL, default 4, meaning input channels accumulated per pixel (>=1).
REQ-003 SHALL have parameter OUTPUT_CHANNEL, default 32, meaning parallel output channels.
REQ-004 SHALL have parameter INPUT_SIZE, default 6, meaning frame side length; pixels per frame = INPUT_SIZE^2.
REQ-005 SHALL have parameter ACC_W, default 32, meaning signed accumulator and bias width.
REQ-006 SHALL have parameter RELU, default 1, meaning clamp negatives to 0 when 1.
REQ-007 SHALL have ports: clk  in  1  clock; rst  in  1  reset.
REQ-008 SHALL have ports: input_vld  in  1  beat valid; input_rdy  out  1  beat accepted when both high.
REQ-009 SHALL have ports: input_din  in  N  signed activation of current channel; weight_din  in  OUTPUT_CHANNEL*N  signed weights for current channel, channel o at [(o+1)*N-1:o*N].
REQ-010 SHALL have ports: bias_din  in  OUTPUT_CHANNEL*ACC_W  per-channel bias; shift_din  in  OUTPUT_CHANNEL*5  per-channel right shift.
REQ-011 SHALL have ports: conv_dout  out  OUTPUT_CHANNEL*N  result; conv_dout_vld  out  1; conv_dout_rdy  in  1; conv_dout_last  out  1  final pixel of frame; busy  out  1  frame in progress.
REQ-012 Clocking SHALL be one clock, clk; reset rst SHALL be synchronous and active-high.

Function
REQ-013 Beats SHALL arrive channel-major per pixel: INPUT_CHANNEL consecutive accepted beats (ci=0..INPUT_CHANNEL-1) form one pixel.
REQ-014 On accepted beat ci=0, acc[o] SHALL load bias[o] + x*w[o]; on ci>0, acc[o] SHALL load acc[o] + x*w[o]; arithmetic signed, modulo 2^ACC_W (wrap, no saturation).
REQ-015 On accepted beat ci=INPUT_CHANNEL-1, the output register SHALL load, at the same edge, q[o] = sat_N(round(sum) >>> s), sum = accumulated value including this beat, s = shift_din[o], round = add 2^(s-1) only when s>0.
REQ-016 sat_N SHALL clamp to [-2^(N-1), 2^(N-1)-1]; with RELU=1, negatives SHALL become 0 after saturation.
REQ-017 Latency SHALL be 1 edge: conv_dout_vld high the cycle after the last channel beat is accepted.
REQ-018 input_rdy SHALL equal !conv_dout_vld || conv_dout_rdy (combinational), stalling all beats while a result is held.
REQ-019 conv_dout_vld SHALL clear on the edge where conv_dout_vld && conv_dout_rdy unless a new result loads on that same edge, in which case it stays high with new data.
REQ-020 conv_dout and conv_dout_last SHALL hold stable while conv_dout_vld && !conv_dout_rdy.
REQ-021 Counters ci (0..INPUT_CHANNEL-1) and pix (0..INPUT_SIZE^2-1) SHALL advance only on accepted beats and wrap to 0 after their maxima.
REQ-022 conv_dout_last SHALL be 1 with the result of pix = INPUT_SIZE^2-1, else 0.
REQ-023 FSM states: IDLE (busy=0), RUN (busy=1), DRAIN (busy=1); IDLE->RUN on first accepted beat; RUN->DRAIN when last beat of last pixel accepted; DRAIN->IDLE when last result handshakes; DRAIN->RUN if a new frame beat is accepted on that same edge.
REQ-024 With INPUT_CHANNEL=1, every accepted beat SHALL produce one result (ci stays 0).
REQ-025 bias_din and shift_din SHALL be sampled on the ci=0 beat and last-channel beat respectively.

Reset
REQ-026 On rst: conv_dout=0, conv_dout_vld=0, conv_dout_last=0, busy=0, ci=0, pix=0, acc=0, state=IDLE; input_rdy=1 following reset.
REQ-027 Reset mid-frame SHALL discard partial accumulation and any held result; next beat is treated as ci=0, pix=0.

Structure
REQ-028 Shared package SHALL hold FSM state encodings and sat/round width constants; parameters stay on the module.
REQ-029 One sub-module pconv_mac_cn SHALL implement one channel's accumulator, round/shift, saturation and ReLU, instantiated OUTPUT_CHANNEL times by generate.

Verification
REQ-030 IC=4, N=16, x=1,2,3,4, w[0]=1 each, bias=10, shift=0 -> conv_dout[0]=20, vld one cycle after 4th beat.
REQ-031 x=100, w=400, bias=0, shift=0, IC=1 -> 40000 saturates to 32767; w=-400 with RELU=1 -> 0; RELU=0 -> -32768.
REQ-032 sum=7, shift=2 -> (7+2)>>>2 = 2; sum=-7, shift=2 -> -2.
REQ-033 conv_dout_rdy low 5 cycles with result held -> input_rdy=0, conv_dout stable, no beat lost; release -> stream resumes, all 36 results correct in order.
REQ-034 Full 6x6 frame, IC=4 -> 36 results, conv_dout_last only on 36th, busy falls after its handshake; back-to-back frame keeps busy=1.
REQ-035 rst asserted after 2 beats of pixel 5 -> outputs cleared; fresh frame yields expected first-pixel value.
